// File: rtl/german_sched_pkg.sv
// Shared types and constants for the German-protocol rule scheduler.
// Includes the FSM state encoding, the idle select code, the LFSR taps and a wrap helper.
package german_sched_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      STALLED = 2'd2
   } sched_state_e;

   // All-ones select code; the top slices it down to its io_en_a width.
   localparam logic [31:0] EN_NONE   = 32'hFFFF_FFFF;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/german_rule_scheduler_rr_pick.sv
// Rotating-priority encoder: returns the first set request at or after base, wrapping.
// The request vector is rotated so that bit 0 lines up with base, then a plain priority encode follows.
module german_rr_pick #(
   parameter int NUM_RULES = 24,
   parameter int EN_W      = 5
) (
   input  logic [NUM_RULES-1:0] req,
   input  logic [EN_W-1:0]      base,
   output logic [EN_W-1:0]      idx,
   output logic                 any
);

   localparam logic [EN_W:0] N_EXT = (EN_W + 1)'(NUM_RULES);

   logic [2*NUM_RULES-1:0] dbl;
   logic [NUM_RULES-1:0]   rot;
   logic [EN_W-1:0]        off;
   logic [EN_W:0]          sum;

   assign dbl = {req, req};
   assign rot = NUM_RULES'(dbl >> base);
   assign any = |req;

   always_comb begin
      off = '0;
      for (int k = NUM_RULES - 1; k >= 0; k--) begin
         if (rot[k]) off = EN_W'(k);
      end
      sum = {1'b0, base} + {1'b0, off};
      if (sum >= N_EXT) sum = sum - N_EXT;
      idx = sum[EN_W-1:0];
   end

endmodule

// File: rtl/german_rule_scheduler.sv
// Picks one enabled rule per cycle for the German coherence system, round-robin or LFSR-random,
// with forced round-robin grants for fairness and a sticky deadlock flag when no guard holds.
module german_rule_scheduler
   import german_sched_pkg::*;
#(
   parameter int          NUM_RULES      = 24,
   parameter int          EN_W           = 5,
   parameter int          FORCE_RR_EVERY = 8,
   parameter int          DEADLOCK_LIMIT = 7,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 halt,
   input  logic                 mode,
   input  logic [NUM_RULES-1:0] guard_vec,
   output logic [EN_W-1:0]      io_en_a,
   output logic                 en_valid,
   output logic                 deadlock,
   output logic [15:0]          fire_count,
   output logic                 busy
);

   localparam int            GC_W     = (FORCE_RR_EVERY > 1) ? $clog2(FORCE_RR_EVERY) : 1;
   localparam int            IC_W     = $clog2(DEADLOCK_LIMIT + 1);
   localparam logic [GC_W-1:0] GC_LAST  = GC_W'(FORCE_RR_EVERY - 1);
   localparam logic [IC_W-1:0] IC_LIMIT = IC_W'(DEADLOCK_LIMIT);
   localparam logic [EN_W:0] N_EXT    = (EN_W + 1)'(NUM_RULES);
   localparam logic [EN_W-1:0] SEL_NONE = EN_NONE[EN_W-1:0];

   sched_state_e      state_q, state_d;
   logic [EN_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [GC_W-1:0]   grant_cnt_q, grant_cnt_d;
   logic [IC_W-1:0]   idle_cnt_q, idle_cnt_d;
   logic [15:0]       fire_count_q, fire_count_d;
   logic              deadlock_q, deadlock_d;

   logic              live, fire, pick_any;
   logic [EN_W-1:0]   r_raw, r_sub, rand_base, base, pick_idx;

   assign live = (state_q == RUN) && !reset;

   // Fold the LFSR slice into range; leftovers that are still too large fall back to 0.
   always_comb begin
      r_raw = lfsr_q[EN_W-1:0];
      r_sub = r_raw;
      if ({1'b0, r_raw} >= N_EXT) r_sub = r_raw - N_EXT[EN_W-1:0];
      rand_base = ({1'b0, r_sub} >= N_EXT) ? '0 : r_sub;
      base = (mode && (grant_cnt_q != GC_LAST)) ? rand_base : rr_ptr_q;
   end

   german_rr_pick #(
      .NUM_RULES (NUM_RULES),
      .EN_W      (EN_W)
   ) u_pick (
      .req  (guard_vec),
      .base (base),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   assign fire = live && pick_any;

   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (halt) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idle_cnt_d == IC_LIMIT) state_d = STALLED;
            STALLED: if (start) state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      io_en_a  = fire ? pick_idx : SEL_NONE;
      en_valid = fire;
      busy     = (state_q == RUN);
   end

   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      lfsr_d       = lfsr_q;
      grant_cnt_d  = grant_cnt_q;
      idle_cnt_d   = idle_cnt_q;
      fire_count_d = fire_count_q;
      deadlock_d   = deadlock_q;
      if (state_q == RUN) begin
         lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
         if (guard_vec == '0) begin
            if (idle_cnt_q != IC_LIMIT) idle_cnt_d = idle_cnt_q + 1'b1;
         end else begin
            idle_cnt_d = '0;
         end
         if (fire) begin
            rr_ptr_d     = EN_W'(wrap_inc(int'(pick_idx), NUM_RULES));
            grant_cnt_d  = (grant_cnt_q == GC_LAST) ? '0 : grant_cnt_q + 1'b1;
            if (fire_count_q != 16'hFFFF) fire_count_d = fire_count_q + 16'd1;
         end
      end
      if (state_q != RUN && state_d == RUN) fire_count_d = '0;
      if (state_q == STALLED && state_d == RUN) begin
         idle_cnt_d = '0;
         deadlock_d = 1'b0;
      end
      if (state_q == RUN && state_d == STALLED) deadlock_d = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr_q     <= '0;
         lfsr_q       <= LFSR_SEED;
         grant_cnt_q  <= '0;
         idle_cnt_q   <= '0;
         fire_count_q <= '0;
         deadlock_q   <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         lfsr_q       <= lfsr_d;
         grant_cnt_q  <= grant_cnt_d;
         idle_cnt_q   <= idle_cnt_d;
         fire_count_q <= fire_count_d;
         deadlock_q   <= deadlock_d;
      end
   end

   assign fire_count = fire_count_q;
   assign deadlock   = deadlock_q;

endmodule

// File: tb/tb_german_rule_scheduler.sv
// Directed bench for german_rule_scheduler: inputs change just after the rising edge,
// outputs are compared on the falling edge against hand-derived values and a small LFSR model.
module tb_german_rule_scheduler;

   logic        clk = 1'b0;
   logic        reset, start, halt, mode;
   logic [23:0] guard_vec;
   logic [4:0]  io_en_a;
   logic        en_valid, deadlock, busy;
   logic [15:0] fire_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   german_rule_scheduler dut (
      .clock      (clk),
      .reset      (reset),
      .start      (start),
      .halt       (halt),
      .mode       (mode),
      .guard_vec  (guard_vec),
      .io_en_a    (io_en_a),
      .en_valid   (en_valid),
      .deadlock   (deadlock),
      .fire_count (fire_count),
      .busy       (busy)
   );

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int          exp_t1 [4];
      logic [15:0] lm;
      int          rr_m, gc_m, r_m, exp_g, prev_g;
      logic [23:0] seen;

      exp_t1 = '{0, 8, 0, 8};
      reset = 1'b1; start = 1'b0; halt = 1'b0; mode = 1'b0; guard_vec = '0;
      nxt(); nxt();

      // Reset values
      reset = 1'b0;
      at_neg();
      chk("rst_io", io_en_a, 5'h1F);
      chk("rst_valid", en_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fc", fire_count, 0);
      chk("rst_dl", deadlock, 0);
      nxt();

      // T1: round-robin over bits 0 and 8
      start = 1'b1; guard_vec = 24'h000101;
      at_neg();
      chk("t1_idle_valid", en_valid, 0);
      nxt();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         at_neg();
         chk("t1_grant", io_en_a, exp_t1[i]);
         chk("t1_valid", en_valid, 1);
         nxt();
      end

      // T2: move rr_ptr to 23, then wrap
      guard_vec = 24'h1 << 22;
      at_neg();
      chk("t1_fc", fire_count, 4);
      chk("t2_g22", io_en_a, 22);
      nxt();
      guard_vec = (24'h1 << 23) | 24'h2;
      at_neg();
      chk("t2_g23", io_en_a, 23);
      nxt();
      at_neg();
      chk("t2_wrap_g1", io_en_a, 1);
      nxt();
      guard_vec = 24'h6;
      at_neg();
      chk("t2_rr2", io_en_a, 2);
      nxt();

      // T3: seven empty cycles stall the scheduler
      guard_vec = '0;
      for (int i = 0; i < 7; i++) begin
         at_neg();
         chk("t3_valid", en_valid, 0);
         chk("t3_busy", busy, 1);
         chk("t3_io", io_en_a, 5'h1F);
         nxt();
      end
      start = 1'b1;
      at_neg();
      chk("t3_stalled", busy, 0);
      chk("t3_dl_set", deadlock, 1);
      nxt();
      start = 1'b0;
      at_neg();
      chk("t3_rerun", busy, 1);
      chk("t3_dl_clr", deadlock, 0);
      chk("t3_fc_clr", fire_count, 0);
      nxt();

      // T5: halt, start+halt collision, reset mid-RUN
      halt = 1'b1; guard_vec = 24'h1 << 5;
      at_neg();
      chk("t5_grant5", io_en_a, 5);
      nxt();
      start = 1'b1;
      at_neg();
      chk("t5_idle", busy, 0);
      chk("t5_idle_io", io_en_a, 5'h1F);
      nxt();
      start = 1'b0; halt = 1'b0;
      at_neg();
      chk("t5_halt_wins", busy, 0);
      chk("t5_idle_io2", io_en_a, 5'h1F);
      chk("t5_fc_hold", fire_count, 1);
      nxt();
      start = 1'b1;
      nxt();
      start = 1'b0;
      at_neg();
      chk("t5_run_valid", en_valid, 1);
      nxt();
      reset = 1'b1;
      at_neg();
      chk("t5_rst_valid", en_valid, 0);
      chk("t5_rst_io", io_en_a, 5'h1F);
      nxt();
      reset = 1'b0;
      at_neg();
      chk("t5_post_busy", busy, 0);
      chk("t5_post_valid", en_valid, 0);
      chk("t5_post_io", io_en_a, 5'h1F);
      chk("t5_post_fc", fire_count, 0);
      chk("t5_post_dl", deadlock, 0);
      nxt();

      // T4: random mode from fresh reset state, all guards on
      start = 1'b1; mode = 1'b1; guard_vec = 24'hFFFFFF;
      nxt();
      start = 1'b0;
      lm = 16'hACE1; rr_m = 0; gc_m = 0; prev_g = 0; seen = '0;
      for (int k = 0; k < 512; k++) begin
         r_m = int'(lm[4:0]);
         if (r_m >= 24) r_m = r_m - 24;
         exp_g = (gc_m == 7) ? rr_m : r_m;
         at_neg();
         chk("t4_grant", io_en_a, exp_g);
         if (k < 64 && (k % 8) == 7) chk("t4_forced_rr", io_en_a, (prev_g + 1) % 24);
         seen[io_en_a] = 1'b1;
         prev_g = int'(io_en_a);
         rr_m = (exp_g + 1) % 24;
         gc_m = (gc_m + 1) % 8;
         lm = lm[0] ? ((lm >> 1) ^ 16'hB400) : (lm >> 1);
         nxt();
      end
      at_neg();
      chk("t4_cover", seen, 24'hFFFFFF);
      chk("t4_fc", fire_count, 512);
      nxt();

      // T6: fire_count saturation
      reset = 1'b1;
      nxt();
      reset = 1'b0; start = 1'b1; mode = 1'b0;
      nxt();
      start = 1'b0;
      repeat (65534) nxt();
      at_neg();
      chk("t6_fc_fffe", fire_count, 16'hFFFE);
      nxt();
      at_neg();
      chk("t6_fc_ffff", fire_count, 16'hFFFF);
      repeat (70000 - 65535) nxt();
      at_neg();
      chk("t6_fc_sat", fire_count, 16'hFFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
